// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer around the viterbi decoder.
// At frame start it clears the decoder BER counters. It then gates exactly
// FRAME_BITS soft symbols into the decoder sink and packs the decoded bits
// MSB-first into bytes on a one-entry ready/valid output. At frame end it
// latches the decoder error and normalization statistics.
//
// Parameters
//   FRAME_BITS   decoded bits (= symbols) per frame, multiple of 8, 8..65528
//   TIMEOUT_CYC  flush watchdog limit in cycles (used only with the macro)
//
// Optional feature macro: VITERBI_CTRL_TIMEOUT_EN
//   When defined, a watchdog aborts FLUSH after TIMEOUT_CYC cycles without a
//   decoded bit and raises timeout. When undefined, timeout is tied to 0.
//
// Ports
//   clk, reset                       clock, async active-high reset
//   start / busy                     frame request (IDLE only) / not idle
//   sym_val, sym_rdy, sym_rr, sym_eras            upstream symbol stream
//   dec_sink_val, dec_sink_rdy, dec_rr, dec_eras_sym  decoder sink side
//   dec_ber_clear                    decoder BER clear (one cycle)
//   dec_source_val, dec_source_rdy, dec_decbit    decoder bit output
//   dec_numerr, dec_normalizations   decoder statistics
//   byte_val, byte_rdy, byte_data    packed byte output, first bit in bit 7
//   frame_done                       one-cycle pulse at frame end
//   frame_numerr, frame_norms        statistics latched at frame end
//   timeout                          sticky watchdog abort flag
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_BITS  = 256,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    input  logic       sym_val,
    output logic       sym_rdy,
    input  logic [3:0] sym_rr,
    input  logic [3:0] sym_eras,
    output logic       dec_sink_val,
    input  logic       dec_sink_rdy,
    output logic [3:0] dec_rr,
    output logic [3:0] dec_eras_sym,
    output logic       dec_ber_clear,
    input  logic       dec_source_val,
    output logic       dec_source_rdy,
    input  logic       dec_decbit,
    input  logic [7:0] dec_numerr,
    input  logic [7:0] dec_normalizations,
    output logic       byte_val,
    input  logic       byte_rdy,
    output logic [7:0] byte_data,
    output logic       frame_done,
    output logic [7:0] frame_numerr,
    output logic [7:0] frame_norms,
    output logic       timeout
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS);

    // Elaboration-time parameter sanity check.
    if ((FRAME_BITS % 8) != 0 || FRAME_BITS < 8 || FRAME_BITS > 65528 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("viterbi_frame_ctrl: illegal FRAME_BITS or TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [6:0]       shreg;
    logic [7:0]       byte_q;
    logic             byte_vq;

    logic sym_done;
    logic bits_done;
    logic sym_open;
    logic bit_open;
    logic byte_last;
    logic sym_hs;
    logic bit_hs;
    logic byte_load;
    logic wd_fire;

    // Handshake gating, all combinational.
    assign sym_done  = (sym_cnt == FRAME_LAST);
    assign bits_done = (bit_cnt == FRAME_LAST);
    assign sym_open  = (state == S_RUN) && !sym_done;
    assign bit_open  = (state == S_RUN) || (state == S_FLUSH);
    assign byte_last = (bit_cnt[2:0] == 3'd7);

    assign sym_rdy      = sym_open && dec_sink_rdy;
    assign dec_sink_val = sym_open && sym_val;
    assign dec_rr       = sym_rr;
    assign dec_eras_sym = sym_eras;
    assign sym_hs       = sym_val && sym_rdy;

    // The 8th bit of a byte is held off while the byte register is full and not draining.
    assign dec_source_rdy = bit_open && !bits_done && !(byte_last && byte_vq && !byte_rdy);
    assign bit_hs         = dec_source_val && dec_source_rdy;
    assign byte_load      = bit_hs && byte_last;

    assign byte_val  = byte_vq;
    assign byte_data = byte_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        dec_ber_clear = 1'b0;
        frame_done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dec_ber_clear = 1'b1;
                state_nxt     = S_RUN;
            end
            S_RUN: begin
                if (sym_done) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leave as the last byte drains so frame_done follows acceptance by one cycle.
                if (wd_fire) begin
                    state_nxt = S_DONE;
                end else if (bits_done && (!byte_vq || byte_rdy)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Symbol/bit counters and the bit shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (state == S_CLEAR) begin
            sym_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (sym_hs) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
            if (bit_hs) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                shreg   <= {shreg[5:0], dec_decbit};
            end
        end
    end

    // One-entry byte register; a load wins over a simultaneous accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_q  <= '0;
            byte_vq <= 1'b0;
        end else if (byte_load) begin
            byte_q  <= {shreg, dec_decbit};
            byte_vq <= 1'b1;
        end else if (byte_rdy) begin
            byte_vq <= 1'b0;
        end
    end

    // Frame statistics, sampled during DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_numerr <= '0;
            frame_norms  <= '0;
        end else if (state == S_DONE) begin
            frame_numerr <= dec_numerr;
            frame_norms  <= dec_normalizations;
        end
    end

`ifdef VITERBI_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Fires on the TIMEOUT_CYC-th consecutive FLUSH cycle without a decoded bit.
    assign wd_fire = (state == S_FLUSH) && !bit_hs && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state == S_FLUSH) && !bit_hs && !wd_fire) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if ((state == S_IDLE) && start) begin
                timeout_q <= 1'b0;
            end else if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl with FRAME_BITS=16, TIMEOUT_CYC=8.
// A frame-level model (symbol/bit counts, a decoded-bit queue and a one-entry
// byte slot) predicts every handshake output cycle by cycle.
module tb_viterbi_frame_ctrl;

    localparam int unsigned FB = 16;
    localparam int unsigned TO = 8;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       sym_val;
    logic       sym_rdy;
    logic [3:0] sym_rr;
    logic [3:0] sym_eras;
    logic       dec_sink_val;
    logic       dec_sink_rdy;
    logic [3:0] dec_rr;
    logic [3:0] dec_eras_sym;
    logic       dec_ber_clear;
    logic       dec_source_val;
    logic       dec_source_rdy;
    logic       dec_decbit;
    logic [7:0] dec_numerr;
    logic [7:0] dec_normalizations;
    logic       byte_val;
    logic       byte_rdy;
    logic [7:0] byte_data;
    logic       frame_done;
    logic [7:0] frame_numerr;
    logic [7:0] frame_norms;
    logic       timeout;

    int total;
    int bad;
    bit prev_to;

    viterbi_frame_ctrl #(
        .FRAME_BITS (FB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .busy              (busy),
        .sym_val           (sym_val),
        .sym_rdy           (sym_rdy),
        .sym_rr            (sym_rr),
        .sym_eras          (sym_eras),
        .dec_sink_val      (dec_sink_val),
        .dec_sink_rdy      (dec_sink_rdy),
        .dec_rr            (dec_rr),
        .dec_eras_sym      (dec_eras_sym),
        .dec_ber_clear     (dec_ber_clear),
        .dec_source_val    (dec_source_val),
        .dec_source_rdy    (dec_source_rdy),
        .dec_decbit        (dec_decbit),
        .dec_numerr        (dec_numerr),
        .dec_normalizations(dec_normalizations),
        .byte_val          (byte_val),
        .byte_rdy          (byte_rdy),
        .byte_data         (byte_data),
        .frame_done        (frame_done),
        .frame_numerr      (frame_numerr),
        .frame_norms       (frame_norms),
        .timeout           (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        start              = 1'b0;
        sym_val            = 1'b0;
        sym_rr             = 4'd0;
        sym_eras           = 4'd0;
        dec_sink_rdy       = 1'b0;
        dec_source_val     = 1'b0;
        dec_decbit         = 1'b0;
        byte_rdy           = 1'b0;
    endtask

    // Checks every output that must be zero while reset is held.
    task automatic check_all_zero(input string tag);
        total++;
        if ({busy, sym_rdy, dec_sink_val, dec_ber_clear, dec_source_rdy, byte_val,
             frame_done, timeout} !== 8'd0 || byte_data !== 8'd0 ||
            frame_numerr !== 8'd0 || frame_norms !== 8'd0) begin
            bad++;
            $display("FAIL %s: outputs busy=%b sym_rdy=%b sink_val=%b clr=%b src_rdy=%b bval=%b bdata=%h done=%b numerr=%h norms=%h to=%b, required all 0",
                     tag, busy, sym_rdy, dec_sink_val, dec_ber_clear, dec_source_rdy, byte_val,
                     byte_data, frame_done, frame_numerr, frame_norms, timeout);
        end
    endtask

    // Runs one frame from start until the byte slot drains after frame end.
    // bits: FB decoded bits, first bit in the MSB. drop: trailing bits never produced.
    task automatic run_frame(input string tag, input logic [FB-1:0] bits,
                             input int sym_p, input int src_p, input int byte_p,
                             input logic [7:0] numerr, input logic [7:0] norms,
                             input int drop, input bit start_noise);
        bit q[$];
        int acc = 0, pushed = 0, bits_got = 0, flush_start = -1, done_cyc = -1;
        int idle = 0, done_seen = 0, pend_idx = 0;
        bit pending = 0, exp_to = 0, finished = 0;
        logic exp_sym_rdy, exp_sink_val, exp_src_rdy, exp_busy, exp_to_now;
        bit bit_active, s_hs, b_hs, pending_b, normal, fire;
        int bits_b;
        for (int c = 0; c < 800 && !finished; c++) begin
            @(negedge clk);
            start = (c == 0) ? 1'b1 :
                    ((start_noise && (done_cyc < 0 || c <= done_cyc)) ? 1'($urandom_range(0, 1)) : 1'b0);
            sym_val            = ($urandom_range(1, 100) <= sym_p);
            dec_sink_rdy       = ($urandom_range(1, 100) <= sym_p);
            sym_rr             = 4'($urandom);
            sym_eras           = 4'($urandom);
            dec_source_val     = (q.size() > 0) && ($urandom_range(1, 100) <= src_p);
            dec_decbit         = (q.size() > 0) ? q[0] : 1'b0;
            byte_rdy           = ($urandom_range(1, 100) <= byte_p);
            dec_numerr         = numerr;
            dec_normalizations = norms;
            #1;
            bit_active   = (c >= 2) && (done_cyc < 0 || c < done_cyc);
            exp_sym_rdy  = (c >= 2) && (acc < FB) && dec_sink_rdy;
            exp_sink_val = (c >= 2) && (acc < FB) && sym_val;
            exp_src_rdy  = bit_active && (bits_got < FB) &&
                           !(((bits_got % 8) == 7) && pending && !byte_rdy);
            exp_busy     = (c >= 1) && (done_cyc < 0 || c <= done_cyc);
`ifdef VITERBI_CTRL_TIMEOUT_EN
            exp_to_now   = (c == 0) ? prev_to : exp_to;
`else
            exp_to_now   = 1'b0;
`endif
            total += 9;
            if (sym_rdy !== exp_sym_rdy) begin
                bad++; $display("FAIL %s sym_rdy c=%0d: got %b want %b", tag, c, sym_rdy, exp_sym_rdy);
            end
            if (dec_sink_val !== exp_sink_val) begin
                bad++; $display("FAIL %s dec_sink_val c=%0d: got %b want %b", tag, c, dec_sink_val, exp_sink_val);
            end
            if (dec_rr !== sym_rr || dec_eras_sym !== sym_eras) begin
                bad++; $display("FAIL %s passthru c=%0d: got %h/%h want %h/%h", tag, c, dec_rr, dec_eras_sym, sym_rr, sym_eras);
            end
            if (dec_source_rdy !== exp_src_rdy) begin
                bad++; $display("FAIL %s dec_source_rdy c=%0d: got %b want %b", tag, c, dec_source_rdy, exp_src_rdy);
            end
            if (dec_ber_clear !== (c == 1)) begin
                bad++; $display("FAIL %s dec_ber_clear c=%0d: got %b want %b", tag, c, dec_ber_clear, (c == 1));
            end
            if (frame_done !== (c == done_cyc)) begin
                bad++; $display("FAIL %s frame_done c=%0d: got %b want %b", tag, c, frame_done, (c == done_cyc));
            end
            if (busy !== exp_busy) begin
                bad++; $display("FAIL %s busy c=%0d: got %b want %b", tag, c, busy, exp_busy);
            end
            if (byte_val !== pending) begin
                bad++; $display("FAIL %s byte_val c=%0d: got %b want %b", tag, c, byte_val, pending);
            end
            if (timeout !== exp_to_now) begin
                bad++; $display("FAIL %s timeout c=%0d: got %b want %b", tag, c, timeout, exp_to_now);
            end
            if (pending) begin
                total++;
                if (byte_data !== bits[FB-1-8*pend_idx -: 8]) begin
                    bad++; $display("FAIL %s byte_data c=%0d: got %h want %h", tag, c, byte_data, bits[FB-1-8*pend_idx -: 8]);
                end
            end
            if (frame_done === 1'b1) done_seen++;

            // Advance the model across the coming edge.
            s_hs      = exp_sink_val && dec_sink_rdy;
            b_hs      = dec_source_val && exp_src_rdy;
            bits_b    = bits_got;
            pending_b = pending;
            if (b_hs) begin
                void'(q.pop_front());
                bits_got++;
            end
            if (s_hs) begin
                if (pushed < FB - drop) q.push_back(bits[FB-1-pushed]);
                pushed++;
                acc++;
                if (acc == FB) flush_start = c + 2;
            end
            if (b_hs && (bits_b % 8) == 7) begin
                pending  = 1'b1;
                pend_idx = bits_b / 8;
            end else if (byte_rdy) begin
                pending = 1'b0;
            end
            if (done_cyc < 0 && flush_start >= 0 && c >= flush_start) begin
                normal = (bits_b == FB) && (!pending_b || byte_rdy);
                fire   = 1'b0;
`ifdef VITERBI_CTRL_TIMEOUT_EN
                if (b_hs) idle = 0;
                else idle++;
                fire = !b_hs && (idle == TO);
`endif
                if (fire) begin
                    done_cyc = c + 1;
                    exp_to   = 1'b1;
                end else if (normal) begin
                    done_cyc = c + 1;
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 1 && !pending) finished = 1'b1;
        end
        total++;
        if (!finished) begin
            bad++; $display("FAIL %s frame_end: got no end within budget, want frame completion", tag);
        end
        @(negedge clk);
        idle_inputs();
        total += 2;
        if (done_seen != 1) begin
            bad++; $display("FAIL %s frame_done_count: got %0d want 1", tag, done_seen);
        end
        if (frame_numerr !== numerr || frame_norms !== norms) begin
            bad++; $display("FAIL %s stats: got %h/%h want %h/%h", tag, frame_numerr, frame_norms, numerr, norms);
        end
        prev_to = exp_to;
    endtask

    task automatic test_reset();
        idle_inputs();
        dec_numerr         = 8'd0;
        dec_normalizations = 8'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        prev_to = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_frame("basic", 16'hB1F0, 100, 100, 100, 8'h00, 8'h00, 0, 1'b0);
    endtask

    task automatic test_stats_and_start_noise();
        run_frame("stats", 16'h5A3C, 100, 100, 100, 8'd7, 8'd3, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_frame("random", 16'($urandom), 60, 70, 60, 8'($urandom), 8'($urandom), 0, 1'b1);
        end
    endtask

    task automatic test_byte_stall();
        for (int i = 0; i < 3; i++) begin
            run_frame("byte_stall", 16'($urandom), 100, 100, 15, 8'($urandom), 8'($urandom), 0, 1'b0);
        end
    endtask

    task automatic test_midframe_reset();
        @(negedge clk);
        start        = 1'b1;
        sym_val      = 1'b1;
        dec_sink_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (sym_rdy !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL midreset_in_run: got sym_rdy=%b busy=%b want 1/1", sym_rdy, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset_async");
        @(negedge clk);
        reset = 1'b0;
        prev_to = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || frame_done !== 1'b0) begin
                bad++; $display("FAIL midreset_idle: got busy=%b done=%b want 0/0", busy, frame_done);
            end
        end
        run_frame("after_reset", 16'hC3A5, 100, 100, 100, 8'd9, 8'd1, 0, 1'b0);
    endtask

`ifdef VITERBI_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        run_frame("timeout", 16'hB1F0, 100, 100, 100, 8'd4, 8'd2, 3, 1'b0);
        run_frame("timeout_clear", 16'h0FF0, 100, 100, 100, 8'd1, 8'd6, 0, 1'b0);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_stats_and_start_noise();
        test_random();
        test_byte_stall();
        test_midframe_reset();
`ifdef VITERBI_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame-level sequencer for the `viterbi` decoder. It clears the decoder's BER counters at frame start, gates exactly `FRAME_BITS` soft symbols into the decoder sink, and packs the decoded bits MSB-first into bytes on a ready/valid output. At frame end it latches the decoder's `numerr` and `normalizations`. It sits between the demodulator symbol stream and the byte-level receive path.

## Interface
- `FRAME_BITS`, 256: decoded bits per frame (= symbols per frame); must be a multiple of 8, range 8..65528.
- `TIMEOUT_CYC`, 1024: flush watchdog limit in cycles (used only with the macro).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; one clock domain.
- `start`  in  1  frame start request; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `sym_val` / `sym_rdy`  in / out  1 / 1  upstream symbol handshake.
- `sym_rr`, `sym_eras`  in  4, 4  soft symbol and erasure flags.
- `dec_sink_val` / `dec_sink_rdy`  out / in  1 / 1  decoder sink handshake.
- `dec_rr`, `dec_eras_sym`  out  4, 4  combinational pass-through of `sym_rr` and `sym_eras`.
- `dec_ber_clear`  out  1  decoder BER clear.
- `dec_source_val` / `dec_source_rdy`  in / out  1 / 1  decoder output handshake.
- `dec_decbit`  in  1  decoded bit.
- `dec_numerr`, `dec_normalizations`  in  8, 8  decoder statistics.
- `byte_val` / `byte_rdy`  out / in  1 / 1  packed byte handshake.
- `byte_data`  out  8  packed byte; first decoded bit is in bit 7.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `frame_numerr`, `frame_norms`  out  8, 8  statistics latched at frame end.
- `timeout`  out  1  frame aborted by the watchdog; sticky until the next accepted `start`.

## Operation
- States and transitions:
  - IDLE: `start` moves to CLEAR.
  - CLEAR: lasts 1 cycle, then RUN.
  - RUN: stays until `sym_cnt == FRAME_BITS`, then FLUSH.
  - FLUSH: stays until `bit_cnt == FRAME_BITS` and the byte register is empty, then DONE.
  - DONE: lasts 1 cycle, then IDLE.
- CLEAR:
  - `dec_ber_clear = 1`.
  - `sym_cnt`, `bit_cnt` and the shift register are zeroed.
  - `timeout` is cleared.
- RUN:
  - `dec_sink_val = sym_val` and `sym_rdy = dec_sink_rdy`, both combinational.
  - `sym_cnt` increments on each `sym_val && sym_rdy`.
- Outside RUN: `sym_rdy = 0` and `dec_sink_val = 0`.
- Decoded bits, in RUN and FLUSH:
  - `dec_source_rdy = 1` unless `bit_cnt == FRAME_BITS`, or this is the 8th bit of a byte and `byte_val && !byte_rdy`.
  - Each decoded-bit handshake shifts `dec_decbit` in and increments `bit_cnt`.
  - On the 8th bit, the full byte loads `byte_data` and sets `byte_val` on the next edge.
- Byte register:
  - One entry. `byte_val` holds until `byte_rdy`.
  - A load and an accept in the same cycle are legal; the new byte replaces the old one with no bubble.
- DONE:
  - `frame_done = 1`.
  - `frame_numerr` / `frame_norms` capture `dec_numerr` / `dec_normalizations`.
- Counters are 16 bits and do not wrap within a frame.
- `start` outside IDLE is ignored.
- Reset:
  - All outputs are 0; the state is IDLE.
  - `frame_numerr` and `frame_norms` are 0.
  - Reset mid-frame abandons the frame with no `frame_done`. The decoder is not cleared until the next CLEAR.

## Timing
- `start` high in cycle 0 gives `dec_ber_clear` high in cycle 1 only. RUN begins in cycle 2, where `sym_rdy` may first be high.
- Symbol path latency: 0 cycles, combinational.
- `byte_val` rises 1 cycle after the 8th bit handshake.
- `frame_done` rises 1 cycle after the cycle in which the last byte is accepted (which occurs in FLUSH).
- Throughput: 1 symbol and 1 decoded bit per cycle, sustained while `byte_rdy = 1`.

## Configuration
- `VITERBI_CTRL_TIMEOUT_EN` defined:
  - In FLUSH, a cycle counter counts cycles without a decoded-bit handshake and resets on each handshake.
  - When the counter reaches `TIMEOUT_CYC`, the block goes to DONE with `timeout = 1`.
  - The partial shift-register contents are discarded.
  - A byte already in the byte register stays valid until accepted.
- Not defined:
  - FLUSH waits indefinitely.
  - `timeout` is tied to 0 and no watchdog logic exists.

## Test plan
- `FRAME_BITS=16`, `start`, 16 symbols back-to-back, decoder returning bits 1,0,1,1,0,0,0,1,1,1,1,1,0,0,0,0 with `byte_rdy=1` -> bytes 0xB1, 0xF0; `dec_ber_clear` high exactly in cycle 1; one `frame_done` pulse.
- After 16 symbols are accepted, `sym_val` held high -> `sym_rdy=0` and `dec_sink_val=0` for the rest of the frame.
- `byte_rdy=0` while the 16th bit is offered -> `dec_source_rdy=0` on that bit; `byte_rdy` high for 1 cycle -> 0xB1 accepted, 0xF0 loads with no bubble.
- `dec_numerr=7`, `dec_normalizations=3` at DONE -> `frame_numerr=7`, `frame_norms=3`; `start` during RUN is ignored.
- `reset` asserted mid-RUN -> all outputs 0 immediately, state IDLE; the next `start` runs a clean frame.
- With `VITERBI_CTRL_TIMEOUT_EN` and `TIMEOUT_CYC=8`, decoder stalls in FLUSH -> `timeout=1` and `frame_done` after 8 idle cycles; `timeout` clears on the next `start`.
